// File: rtl/gcn_engine.sv
// Two-layer graph convolution engine: aggregate, dense+ReLU, aggregate, dense.
// One neuron per cycle is evaluated for all nodes in parallel; a job is exchanged via valid/ready.
module gcn_engine #(
    parameter int N_NODES = 4,
    parameter int N_IN    = 4,
    parameter int N_HID   = 4,
    parameter int N_OUT   = 2,
    parameter int DW      = 5,
    parameter int WW      = 5,
    parameter int HID_W   = 13,
    parameter int OUT_W   = 21
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_NODES*N_IN*DW-1:0]       x_in,
    input  logic [N_NODES*N_NODES-1:0]       adj,
    input  logic [N_HID*N_IN*WW-1:0]         w1,
    input  logic [N_OUT*N_HID*WW-1:0]        w2,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_NODES*N_OUT*OUT_W-1:0]   y_out,
    output logic                             busy
);

    localparam int AX_W = DW + $clog2(N_NODES) + 1;
    localparam int P1_W = AX_W + WW + $clog2(N_IN) + 1;
    localparam int AH_W = HID_W + $clog2(N_NODES) + 1;
    localparam int P2_W = AH_W + WW + $clog2(N_HID) + 1;
    localparam int HS_W = (P1_W > HID_W) ? P1_W : HID_W;
    localparam int OS_W = (P2_W > OUT_W) ? P2_W : OUT_W;
    localparam int HC_W = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int OC_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic signed [HS_W-1:0] HID_MAX = {{(HS_W-HID_W+1){1'b0}}, {(HID_W-1){1'b1}}};
    localparam logic signed [OS_W-1:0] OUT_MAX = {{(OS_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [OS_W-1:0] OUT_MIN = {{(OS_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_AGG1, S_L1, S_AGG2, S_L2, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;
    logic [HC_W-1:0]         r_h;
    logic [OC_W-1:0]         r_o;
    logic signed [DW-1:0]    r_x   [N_NODES][N_IN];
    logic [N_NODES*N_NODES-1:0] r_adj;
    logic signed [WW-1:0]    r_w1  [N_HID][N_IN];
    logic signed [WW-1:0]    r_w2  [N_OUT][N_HID];
    logic signed [AX_W-1:0]  r_ax  [N_NODES][N_IN];
    logic signed [HID_W-1:0] r_hid [N_NODES][N_HID];
    logic signed [AH_W-1:0]  r_ah  [N_NODES][N_HID];
    logic [N_NODES*N_OUT*OUT_W-1:0] r_y;

    logic signed [AX_W-1:0]  w_ax  [N_NODES][N_IN];
    logic signed [HID_W-1:0] w_hid [N_NODES];
    logic signed [AH_W-1:0]  w_ah  [N_NODES][N_HID];
    logic signed [OUT_W-1:0] w_y   [N_NODES];

    // Datapath: both aggregations in full, plus the single neuron selected by r_h / r_o.
    always_comb begin
        logic signed [AX_W-1:0] v_ax;
        logic signed [AH_W-1:0] v_ah;
        logic signed [HS_W-1:0] v_acc1;
        logic signed [OS_W-1:0] v_acc2;
        v_ax   = '0;
        v_ah   = '0;
        v_acc1 = '0;
        v_acc2 = '0;
        for (int i = 0; i < N_NODES; i++) begin
            for (int f = 0; f < N_IN; f++) begin
                v_ax = '0;
                for (int j = 0; j < N_NODES; j++)
                    if (r_adj[i*N_NODES+j]) v_ax = v_ax + AX_W'(r_x[j][f]);
                w_ax[i][f] = v_ax;
            end
            for (int h = 0; h < N_HID; h++) begin
                v_ah = '0;
                for (int j = 0; j < N_NODES; j++)
                    if (r_adj[i*N_NODES+j]) v_ah = v_ah + AH_W'(r_hid[j][h]);
                w_ah[i][h] = v_ah;
            end

            v_acc1 = '0;
            for (int f = 0; f < N_IN; f++)
                v_acc1 = v_acc1 + HS_W'(r_ax[i][f]) * HS_W'(r_w1[r_h][f]);
            if (v_acc1[HS_W-1])          w_hid[i] = '0;
            else if (v_acc1 > HID_MAX)   w_hid[i] = HID_MAX[HID_W-1:0];
            else                         w_hid[i] = v_acc1[HID_W-1:0];

            v_acc2 = '0;
            for (int h = 0; h < N_HID; h++)
                v_acc2 = v_acc2 + OS_W'(r_ah[i][h]) * OS_W'(r_w2[r_o][h]);
            if (v_acc2 > OUT_MAX)        w_y[i] = OUT_MAX[OUT_W-1:0];
            else if (v_acc2 < OUT_MIN)   w_y[i] = OUT_MIN[OUT_W-1:0];
            else                         w_y[i] = v_acc2[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_h         <= '0;
            r_o         <= '0;
            r_adj       <= '0;
            r_y         <= '0;
            // NOTE: the operand/intermediate arrays are small registers, not RAM, so they are cleared too.
            for (int n = 0; n < N_NODES; n++) begin
                for (int f = 0; f < N_IN; f++) begin
                    r_x[n][f]  <= '0;
                    r_ax[n][f] <= '0;
                end
                for (int h = 0; h < N_HID; h++) begin
                    r_hid[n][h] <= '0;
                    r_ah[n][h]  <= '0;
                end
            end
            for (int h = 0; h < N_HID; h++)
                for (int f = 0; f < N_IN; f++) r_w1[h][f] <= '0;
            for (int o = 0; o < N_OUT; o++)
                for (int h = 0; h < N_HID; h++) r_w2[o][h] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int n = 0; n < N_NODES; n++)
                            for (int f = 0; f < N_IN; f++)
                                r_x[n][f] <= x_in[(n*N_IN+f)*DW +: DW];
                        for (int h = 0; h < N_HID; h++)
                            for (int f = 0; f < N_IN; f++)
                                r_w1[h][f] <= w1[(h*N_IN+f)*WW +: WW];
                        for (int o = 0; o < N_OUT; o++)
                            for (int h = 0; h < N_HID; h++)
                                r_w2[o][h] <= w2[(o*N_HID+h)*WW +: WW];
                        r_adj      <= adj;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_AGG1;
                    end
                end
                S_AGG1: begin
                    r_ax    <= w_ax;
                    r_h     <= '0;
                    r_state <= S_L1;
                end
                S_L1: begin
                    for (int n = 0; n < N_NODES; n++) r_hid[n][r_h] <= w_hid[n];
                    if (r_h == HC_W'(N_HID-1)) begin
                        r_h     <= '0;
                        r_state <= S_AGG2;
                    end else begin
                        r_h <= r_h + 1'b1;
                    end
                end
                S_AGG2: begin
                    r_ah    <= w_ah;
                    r_o     <= '0;
                    r_state <= S_L2;
                end
                S_L2: begin
                    for (int n = 0; n < N_NODES; n++)
                        r_y[(n*N_OUT + int'(r_o))*OUT_W +: OUT_W] <= w_y[n];
                    if (r_o == OC_W'(N_OUT-1)) begin
                        r_o         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_o <= r_o + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign y_out     = r_y;

endmodule

// File: tb/tb_gcn_engine.sv
// Self-checking bench for gcn_engine: plain-arithmetic graph model plus directed literal cases.
// A second instance with OUT_W=16 shares all inputs to exercise output saturation.
module tb_gcn_engine;

    localparam int N   = 4;
    localparam int NI  = 4;
    localparam int NH  = 4;
    localparam int NO  = 2;
    localparam int DW  = 5;
    localparam int WW  = 5;
    localparam int HW  = 13;
    localparam int OW  = 21;
    localparam int OW2 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic in_ready2, out_valid2, busy2;
    logic [N*NI*DW-1:0]  x_in = '0;
    logic [N*N-1:0]      adj = '0;
    logic [NH*NI*WW-1:0] w1 = '0;
    logic [NO*NH*WW-1:0] w2 = '0;
    logic [N*NO*OW-1:0]  y_out;
    logic [N*NO*OW2-1:0] y_out2;

    int n_checks = 0;
    int n_fail   = 0;
    longint exp_y   [N][NO];
    longint exp_y16 [N][NO];
    longint held_y  [N][NO];
    longint held_y16[N][NO];

    gcn_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .adj(adj), .w1(w1), .w2(w2),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy)
    );

    gcn_engine #(.OUT_W(OW2)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x_in(x_in), .adj(adj), .w1(w1), .w2(w2),
        .out_valid(out_valid2), .out_ready(out_ready), .y_out(y_out2), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ydut(input int n, input int o);
        return longint'($signed(y_out[(n*NO+o)*OW +: OW]));
    endfunction

    function automatic longint ydut16(input int n, input int o);
        return longint'($signed(y_out2[(n*NO+o)*OW2 +: OW2]));
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << (w-1)) - 1;
        if (v > mx)      return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    // Reference: evaluate the whole network straight from the offered job vectors.
    task automatic model_compute();
        longint ax [N][NI];
        longint hid[N][NH];
        longint ah [N][NH];
        longint acc;
        longint hmax = (longint'(1) << (HW-1)) - 1;
        for (int i = 0; i < N; i++)
            for (int f = 0; f < NI; f++) begin
                ax[i][f] = 0;
                for (int j = 0; j < N; j++)
                    if (adj[i*N+j]) ax[i][f] += longint'($signed(x_in[(j*NI+f)*DW +: DW]));
            end
        for (int i = 0; i < N; i++)
            for (int h = 0; h < NH; h++) begin
                acc = 0;
                for (int f = 0; f < NI; f++)
                    acc += ax[i][f] * longint'($signed(w1[(h*NI+f)*WW +: WW]));
                hid[i][h] = (acc < 0) ? 0 : ((acc > hmax) ? hmax : acc);
            end
        for (int i = 0; i < N; i++)
            for (int h = 0; h < NH; h++) begin
                ah[i][h] = 0;
                for (int j = 0; j < N; j++)
                    if (adj[i*N+j]) ah[i][h] += hid[j][h];
            end
        for (int i = 0; i < N; i++)
            for (int o = 0; o < NO; o++) begin
                acc = 0;
                for (int h = 0; h < NH; h++)
                    acc += ah[i][h] * longint'($signed(w2[(o*NH+h)*WW +: WW]));
                exp_y[i][o]   = sat(acc, OW);
                exp_y16[i][o] = sat(acc, OW2);
            end
    endtask

    // Continuous comparison against the model whenever outputs carry meaning.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_valid_exclusive", longint'(in_ready && out_valid), 0);
            check("busy_vs_in_ready", longint'(busy), longint'(!in_ready));
            check("out_valid_16_vs_21", longint'(out_valid2), longint'(out_valid));
            if (out_valid) begin
                for (int n = 0; n < N; n++)
                    for (int o = 0; o < NO; o++) begin
                        check($sformatf("model_y[%0d][%0d]", n, o), ydut(n, o), exp_y[n][o]);
                        check($sformatf("model_y16[%0d][%0d]", n, o), ydut16(n, o), exp_y16[n][o]);
                        held_y[n][o]   = exp_y[n][o];
                        held_y16[n][o] = exp_y16[n][o];
                    end
            end else if (in_ready) begin
                for (int n = 0; n < N; n++)
                    for (int o = 0; o < NO; o++) begin
                        check($sformatf("held_y[%0d][%0d]", n, o), ydut(n, o), held_y[n][o]);
                        check($sformatf("held_y16[%0d][%0d]", n, o), ydut16(n, o), held_y16[n][o]);
                    end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_held();
        for (int n = 0; n < N; n++)
            for (int o = 0; o < NO; o++) begin
                held_y[n][o]   = 0;
                held_y16[n][o] = 0;
            end
    endtask

    task automatic set_uniform(input int xv, input int w1v, input int w2v, input logic [N*N-1:0] a);
        for (int k = 0; k < N*NI; k++)  x_in[k*DW +: DW] = DW'(xv);
        for (int k = 0; k < NH*NI; k++) w1[k*WW +: WW]   = WW'(w1v);
        for (int k = 0; k < NO*NH; k++) w2[k*WW +: WW]   = WW'(w2v);
        adj = a;
    endtask

    task automatic set_random(input logic [N*N-1:0] a);
        for (int k = 0; k < N*NI; k++)  x_in[k*DW +: DW] = DW'($urandom);
        for (int k = 0; k < NH*NI; k++) w1[k*WW +: WW]   = WW'($urandom);
        for (int k = 0; k < NO*NH; k++) w2[k*WW +: WW]   = WW'($urandom);
        adj = a;
    endtask

    // Offer the current vectors, then wait (bounded) for out_valid; leaves the bench on that cycle.
    task automatic run_job(input string tag);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin tick(); k++; end
        check({tag, "_in_ready_before_accept"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        model_compute();
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 30) begin tick(); k++; end
        check({tag, "_latency"}, k, 8);
    endtask

    task automatic expect_one_cycle(input string tag);
        tick();
        check({tag, "_out_valid_dropped"}, longint'(out_valid), 0);
        check({tag, "_in_ready_after_handshake"}, longint'(in_ready), 1);
    endtask

    initial begin
        int cnt;
        clear_held();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_y_zero", longint'(y_out == '0), 1);

        // Diamond graph, all ones: ax=3, hid=12, ah=36, y=144.
        set_uniform(1, 1, 1, 16'hEDB7);
        run_job("diamond");
        for (int n = 0; n < N; n++)
            for (int o = 0; o < NO; o++)
                check($sformatf("diamond_y%0d%0d", n, o), ydut(n, o), 144);
        expect_one_cycle("diamond");

        // Negative first-layer weights: ReLU clamps every hidden value to 0.
        set_uniform(1, -1, 1, 16'hEDB7);
        run_job("relu");
        for (int n = 0; n < N; n++)
            for (int o = 0; o < NO; o++)
                check($sformatf("relu_y%0d%0d", n, o), ydut(n, o), 0);
        expect_one_cycle("relu");

        // Fully connected, extreme negatives: hidden saturates at 4095.
        set_uniform(-16, -16, -16, 16'hFFFF);
        run_job("sat");
        for (int n = 0; n < N; n++)
            for (int o = 0; o < NO; o++) begin
                check($sformatf("sat_y%0d%0d", n, o), ydut(n, o), -1048320);
                check($sformatf("sat16_y%0d%0d", n, o), ydut16(n, o), -32768);
            end
        expect_one_cycle("sat");

        // Backpressure with a stray in_valid that must be ignored.
        out_ready = 1'b0;
        set_random(16'hEDB7);
        run_job("bp");
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                in_valid = 1'b1;
                x_in = ~x_in;
            end
            tick();
            check($sformatf("bp_hold_valid_%0d", c), longint'(out_valid), 1);
            check($sformatf("bp_hold_not_ready_%0d", c), longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_out_valid_after_handshake", longint'(out_valid), 0);
        check("bp_in_ready_after_handshake", longint'(in_ready), 1);
        set_random(16'hEDB7);
        run_job("bp_next");
        expect_one_cycle("bp_next");

        // Reset asserted for one cycle while L1 is at h=2.
        set_uniform(1, 1, 1, 16'hEDB7);
        in_valid = 1'b1;
        model_compute();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        clear_held();
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_y_zero", longint'(y_out == '0), 1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("abort_no_result", cnt, 0);
        run_job("after_abort");
        for (int n = 0; n < N; n++)
            for (int o = 0; o < NO; o++)
                check($sformatf("after_abort_y%0d%0d", n, o), ydut(n, o), 144);
        expect_one_cycle("after_abort");

        // Diamond with node 2's row cleared.
        set_uniform(1, 1, 1, 16'hE0B7);
        run_job("row2");
        for (int o = 0; o < NO; o++) begin
            check($sformatf("row2_y0%0d", o), ydut(0, o), 96);
            check($sformatf("row2_y1%0d", o), ydut(1, o), 144);
            check($sformatf("row2_y2%0d", o), ydut(2, o), 0);
            check($sformatf("row2_y3%0d", o), ydut(3, o), 96);
        end
        expect_one_cycle("row2");

        // Identity graph and a few mixed graphs with varied data, checked by the model.
        set_random(16'h8421);
        run_job("identity");
        expect_one_cycle("identity");
        for (int t = 0; t < 3; t++) begin
            set_random(N*N'($urandom));
            run_job($sformatf("mixed%0d", t));
            expect_one_cycle($sformatf("mixed%0d", t));
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
